// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH chained valid/data stages with
// bubble-collapsing back-pressure, synchronous flush and occupancy count.
module elastic_pipe_reg #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic                        push;
  logic                        pop;

  // An empty stage is always ready, so bubbles collapse under a stall
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = !valid_q[i] || r;
      rdy[i] = r;
    end
  end

  assign in_ready = rdy[0] && !flush && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy[0]) begin
      valid_d[0] = push;
      if (push) begin
        data_d[0] = in_data;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = cnt_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg at DEPTH 1..4 sharing one
// stimulus bus; each sequence checks the instance under test.
module tb_elastic_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;

  logic        ir1, ov1, ir2, ov2, ir3, ov3, ir4, ov4;
  logic [31:0] od1, od2, od3, od4;
  logic [0:0]  c1;
  logic [1:0]  c2, c3;
  logic [2:0]  c4;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .count(c1));

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .count(c2));

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .count(c3));

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .count(c4));

  typedef struct {
    int          rs;
    int          fl;
    int          iv;
    logic [31:0] id;
    int          ordy;
    int          eir;
    int          eov;
    logic [31:0] eod;
    int          ecnt;
  } vec_t;

  vec_t        tv[$];
  int          checks = 0;
  int          failures = 0;
  int          dsel = 3;
  logic        p_pend = 1'b0;
  logic [31:0] p_data = '0;
  logic [31:0] exp1 [2];

  function automatic vec_t mk(int rs, int fl, int iv, int id, int ordy,
                              int eir, int eov, int eod, int ecnt);
    vec_t v;
    v.rs = rs; v.fl = fl; v.iv = iv; v.id = 32'(id); v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.eod = 32'(eod); v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic cur_ir();
    case (dsel)
      1:       return ir1;
      2:       return ir2;
      4:       return ir4;
      default: return ir3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; a pending offer must be held unchanged
  task automatic drive(input int rs, input int fl, input int iv,
                       input logic [31:0] id, input int ordy);
    logic ivb;
    ivb = iv[0];
    @(negedge clk);
    if (p_pend) begin
      chk("proto_hold", 32'(ivb && (id == p_data)), 32'd1);
    end
    reset     = rs[0];
    flush     = fl[0];
    in_valid  = ivb;
    in_data   = id;
    out_ready = ordy[0];
    #1;
  endtask

  task automatic tick();
    p_pend = in_valid && !cur_ir() && !flush && !reset;
    p_data = in_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int got;
    logic ordy;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;

    // Reset state of every instance
    drive(1, 0, 0, 0, 0);
    chk("rst_ir1", 32'(ir1), 0);
    chk("rst_ir4", 32'(ir4), 0);
    tick();
    chk("rst_ov1", 32'(ov1), 0);
    chk("rst_c1", 32'(c1), 0);
    chk("rst_ov2", 32'(ov2), 0);
    chk("rst_od2", od2, 0);
    chk("rst_ov4", 32'(ov4), 0);
    chk("rst_c4", 32'(c4), 0);

    // DEPTH=3 table: reset mid-stream, streaming, back-pressure, flush
    tv.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0,    0));
    tv.push_back(mk(0, 0, 1, 'h11, 0, 1, 0, 0,    1));
    tv.push_back(mk(0, 0, 1, 'h22, 0, 1, 0, 0,    2));
    tv.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0,    0));
    tv.push_back(mk(0, 0, 1, 'hA0, 1, 1, 0, 0,    1));
    tv.push_back(mk(0, 0, 1, 'hA1, 1, 1, 0, 0,    2));
    tv.push_back(mk(0, 0, 1, 'hA2, 1, 1, 1, 'hA0, 3));
    tv.push_back(mk(0, 0, 1, 'hA3, 1, 1, 1, 'hA1, 3));
    tv.push_back(mk(0, 0, 1, 'hA4, 1, 1, 1, 'hA2, 3));
    tv.push_back(mk(0, 0, 1, 'hA5, 1, 1, 1, 'hA3, 3));
    tv.push_back(mk(0, 0, 1, 'hA6, 1, 1, 1, 'hA4, 3));
    tv.push_back(mk(0, 0, 1, 'hA7, 1, 1, 1, 'hA5, 3));
    tv.push_back(mk(0, 0, 0, 0,    1, 1, 1, 'hA6, 2));
    tv.push_back(mk(0, 0, 0, 0,    1, 1, 1, 'hA7, 1));
    tv.push_back(mk(0, 0, 0, 0,    1, 1, 0, 'hA7, 0));
    tv.push_back(mk(0, 0, 1, 'h1,  0, 1, 0, 'hA7, 1));
    tv.push_back(mk(0, 0, 1, 'h2,  0, 1, 0, 'hA7, 2));
    tv.push_back(mk(0, 0, 1, 'h3,  0, 1, 1, 'h1,  3));
    tv.push_back(mk(0, 0, 1, 'h4,  0, 0, 1, 'h1,  3));
    tv.push_back(mk(0, 0, 1, 'h4,  0, 0, 1, 'h1,  3));
    tv.push_back(mk(0, 0, 1, 'h4,  1, 1, 1, 'h2,  3));
    tv.push_back(mk(0, 0, 0, 0,    1, 1, 1, 'h3,  2));
    tv.push_back(mk(0, 0, 0, 0,    1, 1, 1, 'h4,  1));
    tv.push_back(mk(0, 0, 0, 0,    1, 1, 0, 'h4,  0));
    tv.push_back(mk(0, 0, 1, 'h55, 0, 1, 0, 'h4,  1));
    tv.push_back(mk(0, 1, 1, 'h66, 0, 0, 0, 0,    0));
    tv.push_back(mk(0, 0, 0, 0,    1, 1, 0, 0,    0));

    dsel = 3;
    foreach (tv[i]) begin
      drive(tv[i].rs, tv[i].fl, tv[i].iv, tv[i].id, tv[i].ordy);
      chk($sformatf("v%0d_in_ready", i), 32'(ir3), 32'(tv[i].eir));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(ov3), 32'(tv[i].eov));
      chk($sformatf("v%0d_out_data", i), od3, tv[i].eod);
      chk($sformatf("v%0d_count", i), 32'(c3), 32'(tv[i].ecnt));
    end

    // DEPTH=4 bubble collapse
    dsel = 4;
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 'h5, 0);
    chk("bub_ir0", 32'(ir4), 1);
    tick();
    chk("bub_c1", 32'(c4), 1);
    chk("bub_ov0", 32'(ov4), 0);
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 'h6, 0);
    chk("bub_ir1", 32'(ir4), 1);
    tick();
    chk("bub_c2", 32'(c4), 2);
    chk("bub_od5", od4, 'h5);
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("bub_ir2", 32'(ir4), 1);
    tick();
    chk("bub_c2b", 32'(c4), 2);
    chk("bub_ov1", 32'(ov4), 1);
    chk("bub_od5b", od4, 'h5);
    drive(0, 0, 0, 0, 1); tick();
    chk("bub_ov2", 32'(ov4), 1);
    chk("bub_od6", od4, 'h6);
    chk("bub_c1b", 32'(c4), 1);
    drive(0, 0, 0, 0, 1); tick();
    chk("bub_ov3", 32'(ov4), 0);
    chk("bub_c0", 32'(c4), 0);
    chk("bub_hold", od4, 'h6);

    // DEPTH=2 flush with simultaneous pop
    dsel = 2;
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 'h7, 0); tick();
    drive(0, 0, 1, 'h8, 0);
    chk("fl_ir_fill", 32'(ir2), 1);
    tick();
    chk("fl_c2", 32'(c2), 2);
    chk("fl_od7", od2, 'h7);
    drive(0, 0, 1, 'h9, 0);
    chk("fl_full_ir", 32'(ir2), 0);
    tick();
    chk("fl_c2b", 32'(c2), 2);
    drive(0, 1, 1, 'h9, 1);
    chk("fl_ir", 32'(ir2), 0);
    chk("fl_pop_ov", 32'(ov2), 1);
    chk("fl_pop_od", od2, 'h7);
    tick();
    chk("fl_c0", 32'(c2), 0);
    chk("fl_ov0", 32'(ov2), 0);
    chk("fl_od0", od2, 0);
    drive(0, 0, 0, 0, 1);
    chk("fl_ir_after", 32'(ir2), 1);
    tick();
    chk("fl_no9", 32'(ov2), 0);

    // DEPTH=1 alternating out_ready
    dsel = 1;
    exp1[0] = 32'hC0;
    exp1[1] = 32'hC1;
    drive(1, 0, 0, 0, 0); tick();
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      ordy = (cyc % 2 == 0);
      drive(0, 0, int'(idx < 2), (idx < 2) ? exp1[idx] : 32'h0, int'(ordy));
      chk($sformatf("d1_ir_c%0d", cyc), 32'(ir1), 32'(!ov1 || ordy));
      if (ov1 && ordy) begin
        if (got < 2) chk($sformatf("d1_data%0d", got), od1, exp1[got]);
        else chk("d1_dup", 32'(ov1), 0);
        got++;
      end
      if (in_valid && ir1) idx++;
      tick();
    end
    chk("d1_sent", 32'(idx), 2);
    chk("d1_got", 32'(got), 2);
    chk("d1_c0", 32'(c1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
